serial_tx: RTL and testbench

Parallel-in, serial-out frame transmitter. It is the driving end of the single-wire serial data line that our D flip-flop capture stages sample on clk. It accepts a WIDTH-bit word over a valid/ready handshake and emits one framed bit stream on sdo: a start bit, then the data bits LSB-first, then a stop bit. Each bit is held for CLKS_PER_BIT clock cycles.

---
 rtl/serial_pkg.sv | 25 ++
 rtl/serial_tx_if.sv | 42 ++++
 rtl/serial_tx_bit_timer.sv | 38 +++
 rtl/serial_tx.sv | 140 ++++++++++++++
 tb/tb_serial_tx.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared types and constants for the serial frame transmitter.
//   state_e    - transmitter FSM states (IDLE -> START -> DATA -> STOP -> IDLE)
//   LINE_IDLE  - level of sdo between frames
//   START_BIT  - level of the start bit
//   STOP_BIT   - level of the stop bit
//   cnt_width  - counter width helper, never narrower than one bit
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Width of a counter that holds 0..n-1; a count of one still needs a bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_tx_if.sv
// serial_tx_if: word handshake plus serial line of the frame transmitter.
//   tx_data  - word to send (master -> slave)
//   tx_valid - tx_data is valid (master -> slave)
//   tx_ready - transmitter can accept a word (slave -> master)
//   sdo      - serial line, idles high (slave -> master)
//   busy     - frame in progress (slave -> master)
//   done     - one-cycle end-of-frame pulse (slave -> master)
//
// Handshake: a word moves on a rising clk edge where tx_valid && tx_ready are
// both high. The master keeps tx_valid and tx_data stable until that edge;
// tx_valid raised while tx_ready is low is simply not seen, never stalled or
// queued.
interface serial_tx_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             sdo;
  logic             busy;
  logic             done;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  sdo,
    input  busy,
    input  done
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output sdo,
    output busy,
    output done
  );

endinterface

// File: rtl/serial_tx_bit_timer.sv
// bit_timer: counts clock cycles inside one bit period.
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   en    - count while high; counter is held at zero while low
//   tick  - high in the last cycle of each bit period (the cycle whose
//           closing edge wraps the counter from CLKS_PER_BIT-1 to 0)
module bit_timer
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int            CW   = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // With CLKS_PER_BIT=1 the counter sits at zero and tick follows en.
  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/serial_tx.sv
// serial_tx: parallel-in, serial-out frame transmitter.
// A WIDTH-bit word accepted over the valid/ready handshake is sent on sdo as
// one start bit, WIDTH data bits LSB-first and one stop bit, each held for
// CLKS_PER_BIT cycles.
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - serial_tx_if slave: tx_data/tx_valid in, tx_ready/sdo/busy/done out
//   state - current FSM state, exposed for observation
module serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_tx_if.slave    bus,
  output state_e        state
);

  localparam int            BW       = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_e            state_q;
  state_e            state_d;
  logic [WIDTH-1:0]  shift_q;
  logic [WIDTH-1:0]  shift_d;
  logic [BW-1:0]     bit_q;
  logic [BW-1:0]     bit_d;
  logic              sdo_q;
  logic              sdo_d;
  logic              ready_q;
  logic              ready_d;
  logic              busy_q;
  logic              busy_d;
  logic              done_q;
  logic              done_d;
  logic              timer_en;
  logic              tick;
  logic              accept;
  logic              last_bit;

  assign timer_en = (state_q != IDLE);
  assign accept   = bus.tx_valid && ready_q;
  assign last_bit = (bit_q == LAST_BIT);

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (timer_en),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)           state_d = START;
      START:   if (tick)             state_d = DATA;
      DATA:    if (tick && last_bit) state_d = STOP;
      STOP:    if (tick)             state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // Shift register and bit counter. The word is loaded on the accepting
  // edge and shifted once per data bit period, so shift_q[0] is always the
  // bit currently on the line while in DATA.
  always_comb begin
    shift_d = shift_q;
    bit_d   = bit_q;
    if (state_q == IDLE && accept) begin
      shift_d = bus.tx_data;
      bit_d   = '0;
    end else if (state_q == DATA && tick) begin
      shift_d = shift_q >> 1;
      bit_d   = last_bit ? '0 : bit_q + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      bit_q   <= '0;
    end else begin
      shift_q <= shift_d;
      bit_q   <= bit_d;
    end
  end

  // Output logic. Outputs are decoded from the upcoming state and registered,
  // so each one changes on the same edge as the state it reflects and sdo is
  // glitch-free.
  always_comb begin
    sdo_d   = LINE_IDLE;
    case (state_d)
      IDLE:    sdo_d = LINE_IDLE;
      START:   sdo_d = START_BIT;
      DATA:    sdo_d = shift_d[0];
      STOP:    sdo_d = STOP_BIT;
      default: sdo_d = LINE_IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
    done_d  = (state_q == STOP) && (state_d == IDLE);
  end

  // tx_ready resets low and first rises on the edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdo_q   <= LINE_IDLE;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sdo_q   <= sdo_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.sdo      = sdo_q;
  assign bus.tx_ready = ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign state        = state_q;

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: bench for serial_tx at WIDTH=8/P=4 and WIDTH=1/P=1.
module tb_serial_tx;
  import serial_pkg::*;

  localparam int W     = 8;
  localparam int P     = 4;
  localparam int FRAME = (W + 2) * P;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_tx_if #(.WIDTH(W)) bus ();
  serial_tx_if #(.WIDTH(1)) bus1 ();
  state_e st8;
  state_e st1;

  serial_tx #(.WIDTH(W), .CLKS_PER_BIT(P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .state (st8)
  );

  serial_tx #(.WIDTH(1), .CLKS_PER_BIT(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1),
    .state (st1)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp    = 0;
  int n_err    = 0;
  int cyc      = 0;
  int done_cnt = 0;
  logic chk_en = 1'b0;
  logic cap1_q;
  logic cap2_q;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got timeout expected event at t=%0t", name, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

  // Two-stage D flip-flop sampler chain on the serial line.
  always @(posedge clk) begin
    cap1_q <= bus.sdo;
    cap2_q <= cap1_q;
  end

  // ---------------- reference model ----------------
  // The line is modelled as a queue of levels, one per cycle: an accepted
  // word appends its whole frame, each edge consumes one level.
  logic exp_ready = 1'b0;
  logic exp_done  = 1'b0;
  logic line_q[$];

  function automatic void push_frame(input logic [W-1:0] d);
    for (int b = 0; b < W + 2; b++) begin
      for (int c = 0; c < P; c++) begin
        if (b == 0)          line_q.push_back(1'b0);
        else if (b == W + 1) line_q.push_back(1'b1);
        else                 line_q.push_back(d[b-1]);
      end
    end
  endfunction

  function automatic logic exp_sdo();
    if (line_q.size() > 0) return line_q[0];
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q.delete();
      exp_ready <= 1'b0;
      exp_done  <= 1'b0;
    end else if (line_q.size() > 0) begin
      exp_done  <= (line_q.size() == 1);
      exp_ready <= (line_q.size() == 1);
      void'(line_q.pop_front());
    end else begin
      exp_done  <= 1'b0;
      exp_ready <= 1'b1;
      if (exp_ready && bus.tx_valid) begin
        push_frame(bus.tx_data);
        exp_ready <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_sdo",   bus.sdo,      exp_sdo());
      chk("cyc_busy",  bus.busy,     line_q.size() > 0);
      chk("cyc_done",  bus.done,     exp_done);
      chk("cyc_ready", bus.tx_ready, exp_ready);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] d, input bit hold);
    int budget = 400;
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    while (bus.tx_ready !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      timeout("send_ready");
      bus.tx_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      if (!hold) bus.tx_valid = 1'b0;
    end
  endtask

  // Decodes one frame from the sampler chain; f[0]=start, f[W+1]=stop.
  task automatic rx(output logic [W+1:0] f, output bit ok);
    int budget = 400;
    ok = 1'b0;
    f  = '0;
    @(negedge clk);
    while (cap2_q !== 1'b0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      timeout("rx_start");
    end else begin
      @(negedge clk);
      f[0] = cap2_q;
      for (int k = 1; k < W + 2; k++) begin
        repeat (P) @(negedge clk);
        f[k] = cap2_q;
      end
      ok = 1'b1;
    end
  endtask

  task automatic score(input logic [W+1:0] f, input bit ok);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      timeout("score_empty");
    end else begin
      e = exp_q.pop_front();
      if (ok) begin
        chk("rx_start_bit", f[0], 1'b0);
        chk("rx_word",      f[W:1], e);
        chk("rx_stop_bit",  f[W+1], 1'b1);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  typedef struct packed {
    logic [W-1:0] data;
    logic [W+1:0] line;
  } vec_t;

  initial begin
    vec_t         vecs[4];
    logic [W+1:0] f;
    logic [W+1:0] f2;
    bit           ok;
    bit           ok2;
    int           d0;
    int           t1;
    int           t2;
    logic [2:0]   p1;

    vecs[0] = '{data: 8'hA5, line: 10'b1101001010};
    vecs[1] = '{data: 8'h3C, line: 10'b1001111000};
    vecs[2] = '{data: 8'h01, line: 10'b1000000010};
    vecs[3] = '{data: 8'h80, line: 10'b1100000000};

    bus.tx_valid  = 1'b0;
    bus.tx_data   = '0;
    bus1.tx_valid = 1'b0;
    bus1.tx_data  = '0;

    // Reset and idle.
    @(posedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_sdo",   bus.sdo,      1'b1);
      chk("rst_ready", bus.tx_ready, 1'b0);
      chk("rst_busy",  bus.busy,     1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready",  bus.tx_ready,  1'b1);
    chk("post_rst_ready1", bus1.tx_ready, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("idle_sdo", bus.sdo, 1'b1);
    end

    // Table-driven single frames.
    for (int i = 0; i < 4; i++) begin
      d0 = done_cnt;
      send(vecs[i].data, 1'b0);
      rx(f, ok);
      if (ok) chk("vec_line", f, vecs[i].line);
      @(negedge clk);
      chk("vec_done_pulse", bus.done, 1'b1);
      @(negedge clk);
      chk("vec_done_count", done_cnt - d0, 1);
      chk("vec_done_low",   bus.done, 1'b0);
    end

    // Back-to-back with tx_valid held high.
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send(8'h00, 1'b1);
    t1 = cyc;
    fork
      begin
        rx(f, ok);
        rx(f2, ok2);
      end
      begin
        send(8'hFF, 1'b0);
        t2 = cyc;
      end
    join
    chk("b2b_period", t2 - t1, FRAME + 1);
    score(f, ok);
    score(f2, ok2);

    // tx_valid pulse during a frame is ignored.
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    send(8'h96, 1'b0);
    fork
      rx(f, ok);
      begin
        repeat (9) @(posedge clk);
        #1;
        bus.tx_data  = 8'h3C;
        bus.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
      end
    join
    if (ok) chk("ign_line", f, 10'b1100101100);
    repeat (20) @(negedge clk);
    chk("ign_done_count", done_cnt - d0, 1);
    chk("ign_busy",       bus.busy, 1'b0);
    chk("ign_state",      st8, IDLE);

    // Reset mid-frame.
    send(8'hC3, 1'b0);
    repeat (18) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_sdo",   bus.sdo,      1'b1);
    chk("midrst_busy",  bus.busy,     1'b0);
    chk("midrst_ready", bus.tx_ready, 1'b0);
    chk("midrst_done",  bus.done,     1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_no_resume", bus.busy, 1'b0);
    exp_q.push_back(8'h5A);
    send(8'h5A, 1'b0);
    rx(f, ok);
    score(f, ok);

    // Randomized frames with random idle gaps.
    for (int i = 0; i < 12; i++) begin
      logic [W-1:0] d;
      d = W'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      exp_q.push_back(d);
      send(d, 1'b0);
      rx(f, ok);
      score(f, ok);
    end
    repeat (4) @(negedge clk);

    // Minimum timing: WIDTH=1, CLKS_PER_BIT=1.
    for (int v = 0; v < 2; v++) begin
      p1 = {1'b1, v[0], 1'b0};
      @(negedge clk);
      bus1.tx_data  = v[0];
      bus1.tx_valid = 1'b1;
      chk("p1_ready_idle", bus1.tx_ready, 1'b1);
      @(posedge clk);
      #1;
      bus1.tx_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
        chk("p1_sdo",  bus1.sdo,  p1[k]);
        chk("p1_busy", bus1.busy, 1'b1);
        chk("p1_done", bus1.done, 1'b0);
        @(posedge clk);
        #1;
      end
      chk("p1_done_end",  bus1.done,     1'b1);
      chk("p1_ready_end", bus1.tx_ready, 1'b1);
      chk("p1_sdo_end",   bus1.sdo,      1'b1);
      chk("p1_busy_end",  bus1.busy,     1'b0);
      @(posedge clk);
      #1;
      chk("p1_done_once", bus1.done, 1'b0);
      chk("p1_state",     st1, IDLE);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    timeout("watchdog");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
